// File: rtl/neopixel_chain.sv
// rtl/neopixel_chain.sv - WS2812/SK6812 chain driver: fetch, serialise and latch one frame
//
// Purpose: on start_tx, reads NBR_PIXELS words from a pixel store with 1-cycle read
// latency, shifts each word out MSB-first as one gap-free frame with programmable bit
// timing, then holds dout low for the latch period and pulses done.
//
// Ports:
//   clk_16MHz  system clock
//   reset      synchronous, active-high
//   start_tx   frame request, honoured only when idle
//   rd_en      pixel store read strobe (single-cycle)
//   rd_addr    pixel index being read
//   rd_data    pixel word, valid the cycle after rd_en
//   dout       serial LED data
//   busy       frame in progress (fetch, send or latch)
//   done       one-cycle pulse after the latch period
module neopixel_chain #(
   parameter int NBR_PIXELS     = 8,
   parameter int BITS_PER_PIXEL = 24,
   parameter int ADDR_W         = 8,
   parameter int T0H            = 6,
   parameter int T1H            = 11,
   parameter int T_BIT          = 20,
   parameter int T_LATCH        = 1280
) (
   input  logic                      clk_16MHz,
   input  logic                      reset,
   input  logic                      start_tx,
   output logic                      rd_en,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [BITS_PER_PIXEL-1:0] rd_data,
   output logic                      dout,
   output logic                      busy,
   output logic                      done
);

   localparam int CYC_W = (T_BIT > 2)          ? $clog2(T_BIT)          : 1;
   localparam int BIT_W = (BITS_PER_PIXEL > 2) ? $clog2(BITS_PER_PIXEL) : 1;
   localparam int LAT_W = (T_LATCH > 2)        ? $clog2(T_LATCH)        : 1;

   localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(T_BIT - 1);
   localparam logic [CYC_W-1:0]  CYC_T0H  = CYC_W'(T0H);
   localparam logic [CYC_W-1:0]  CYC_T1H  = CYC_W'(T1H);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NBR_PIXELS - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(T_LATCH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SEND,
      S_LATCH
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [BITS_PER_PIXEL-1:0] shift_reg;
   logic [BITS_PER_PIXEL-1:0] hold_reg;
   logic [CYC_W-1:0]          cyc_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic [ADDR_W-1:0]         pix_cnt;
   logic [LAT_W-1:0]          lat_cnt;
   logic                      cap_pend;
   logic                      done_r;
   logic                      bit_end;
   logic                      pix_end;

   always_ff @(posedge clk_16MHz) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      dout      = 1'b0;
      busy      = 1'b0;
      bit_end   = (cyc_cnt == CYC_LAST);
      pix_end   = bit_end && (bit_cnt == BIT_LAST);
      case (state)
         S_IDLE: begin
            // done_r blocks the request on the done cycle itself, so a held
            // start_tx re-triggers one cycle later.
            if (start_tx && !done_r) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            busy      = 1'b1;
            rd_en     = 1'b1;
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            busy      = 1'b1;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            busy = 1'b1;
            dout = (cyc_cnt < (shift_reg[BITS_PER_PIXEL-1] ? CYC_T1H : CYC_T0H));
            // Prefetch the next pixel at the start of this pixel's first bit so
            // the word is waiting in hold_reg well before the pixel boundary.
            if ((cyc_cnt == '0) && (bit_cnt == '0) && (pix_cnt != PIX_LAST)) begin
               rd_en   = 1'b1;
               rd_addr = pix_cnt + ADDR_W'(1);
            end
            if (pix_end && (pix_cnt == PIX_LAST)) begin
               state_nxt = S_LATCH;
            end
         end
         S_LATCH: begin
            busy = 1'b1;
            if (lat_cnt == LAT_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign done = done_r;

   always_ff @(posedge clk_16MHz) begin
      if (reset) begin
         shift_reg <= '0;
         hold_reg  <= '0;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         pix_cnt   <= '0;
         lat_cnt   <= '0;
         cap_pend  <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r   <= (state == S_LATCH) && (lat_cnt == LAT_LAST);
         cap_pend <= (state == S_SEND) && rd_en;
         if (cap_pend) begin
            hold_reg <= rd_data;
         end
         case (state)
            S_LOAD: begin
               shift_reg <= rd_data;
               cyc_cnt   <= '0;
               bit_cnt   <= '0;
               pix_cnt   <= '0;
            end
            S_SEND: begin
               lat_cnt <= '0;
               if (bit_end) begin
                  cyc_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (pix_cnt != PIX_LAST) begin
                        pix_cnt   <= pix_cnt + ADDR_W'(1);
                        shift_reg <= hold_reg;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + BIT_W'(1);
                     shift_reg <= shift_reg << 1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            S_LATCH: begin
               lat_cnt <= lat_cnt + LAT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neopixel_chain.sv
// tb/tb_neopixel_chain.sv - scoreboard bench for neopixel_chain (2x24-bit and 1x32-bit chains)
module tb_neopixel_chain;

   localparam int T0H = 6, T1H = 11, T_BIT = 20, T_LATCH = 1280;
   localparam int NA = 2, BA = 24, NB = 1, BB = 32;
   localparam int BUDGET = 6000;

   logic clk_16MHz = 1'b0;
   always #31 clk_16MHz = ~clk_16MHz;

   logic        reset_a, start_a, rd_en_a, dout_a, busy_a, done_a;
   logic [7:0]  rd_addr_a;
   logic [23:0] rd_data_a;
   logic        reset_b, start_b, rd_en_b, dout_b, busy_b, done_b;
   logic [7:0]  rd_addr_b;
   logic [31:0] rd_data_b;

   logic [23:0] mem_a [256];
   logic [31:0] mem_b [256];

   neopixel_chain #(.NBR_PIXELS(NA), .BITS_PER_PIXEL(BA), .ADDR_W(8), .T0H(T0H), .T1H(T1H),
                    .T_BIT(T_BIT), .T_LATCH(T_LATCH)) dut_a (
      .clk_16MHz(clk_16MHz), .reset(reset_a), .start_tx(start_a), .rd_en(rd_en_a),
      .rd_addr(rd_addr_a), .rd_data(rd_data_a), .dout(dout_a), .busy(busy_a), .done(done_a));

   neopixel_chain #(.NBR_PIXELS(NB), .BITS_PER_PIXEL(BB), .ADDR_W(8), .T0H(T0H), .T1H(T1H),
                    .T_BIT(T_BIT), .T_LATCH(T_LATCH)) dut_b (
      .clk_16MHz(clk_16MHz), .reset(reset_b), .start_tx(start_b), .rd_en(rd_en_b),
      .rd_addr(rd_addr_b), .rd_data(rd_data_b), .dout(dout_b), .busy(busy_b), .done(done_b));

   // Pixel stores: 1-cycle latency, garbage on the bus whenever no read was issued.
   always @(posedge clk_16MHz) begin
      if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
      else         rd_data_a <= 24'($urandom);
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
      else         rd_data_b <= $urandom;
   end

   int cyc = 0;
   always @(posedge clk_16MHz) cyc <= cyc + 1;

   logic [1:0] dout_v, rden_v, done_v, busy_v;
   logic [7:0] addr_v [2];
   assign dout_v    = {dout_b, dout_a};
   assign rden_v    = {rd_en_b, rd_en_a};
   assign done_v    = {done_b, done_a};
   assign busy_v    = {busy_b, busy_a};
   assign addr_v[0] = rd_addr_a;
   assign addr_v[1] = rd_addr_b;

   int q_rise    [2][$];
   int q_width   [2][$];
   int q_rd_cyc  [2][$];
   int q_rd_addr [2][$];
   int q_done    [2][$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input int i);
      n_cmp++;
      n_err++;
      $display("FAIL %s[%0d]: event at cycle %0d, expected none", name, i, cyc);
   endtask

   // Reference model: frame accepted at cycle s (start seen idle) yields a fixed
   // event schedule derived from the timing rules.
   task automatic push_frame(input int i, input int s);
      int          npix, bpp, t0;
      logic [31:0] pix;
      npix = (i == 0) ? NA : NB;
      bpp  = (i == 0) ? BA : BB;
      t0   = s + 3;
      q_rd_cyc[i].push_back(s + 1);
      q_rd_addr[i].push_back(0);
      for (int n = 0; n < npix; n++) begin
         pix = (i == 0) ? {8'h00, mem_a[n]} : mem_b[n];
         if (n < npix - 1) begin
            q_rd_cyc[i].push_back(t0 + n * bpp * T_BIT);
            q_rd_addr[i].push_back(n + 1);
         end
         for (int b = 0; b < bpp; b++) begin
            q_rise[i].push_back(t0 + (n * bpp + b) * T_BIT);
            q_width[i].push_back(pix[bpp-1-b] ? T1H : T0H);
         end
      end
      q_done[i].push_back(t0 + npix * bpp * T_BIT + T_LATCH);
   endtask

   task automatic flush(input int i);
      q_rise[i].delete();
      q_width[i].delete();
      q_rd_cyc[i].delete();
      q_rd_addr[i].delete();
      q_done[i].delete();
   endtask

   // Monitor: independent of the stimulus, pops expectations as events appear.
   int         rise_at [2];
   logic [1:0] dout_prev = 2'b00;
   always @(negedge clk_16MHz) begin
      for (int i = 0; i < 2; i++) begin
         if (dout_v[i] && !dout_prev[i]) rise_at[i] <= cyc;
         if (!dout_v[i] && dout_prev[i]) begin
            if (q_rise[i].size() == 0) unexpected("dout pulse", i);
            else begin
               check($sformatf("rise_cycle[%0d]", i), rise_at[i], q_rise[i].pop_front());
               check($sformatf("pulse_width[%0d]", i), cyc - rise_at[i], q_width[i].pop_front());
            end
         end
         if (rden_v[i]) begin
            if (q_rd_cyc[i].size() == 0) unexpected("rd_en", i);
            else begin
               check($sformatf("rd_cycle[%0d]", i), cyc, q_rd_cyc[i].pop_front());
               check($sformatf("rd_addr[%0d]", i), addr_v[i], q_rd_addr[i].pop_front());
            end
         end
         if (done_v[i]) begin
            if (q_done[i].size() == 0) unexpected("done", i);
            else begin
               check($sformatf("done_cycle[%0d]", i), cyc, q_done[i].pop_front());
               check($sformatf("busy_at_done[%0d]", i), busy_v[i], 0);
            end
         end
      end
      dout_prev <= dout_v;
   end

   task automatic tick();
      @(negedge clk_16MHz);
   endtask

   task automatic wait_idle(input int i);
      int k = 0;
      tick();
      while ((busy_v[i] || done_v[i]) && k < BUDGET) begin
         tick();
         k++;
      end
      if (busy_v[i] || done_v[i]) $display("FAIL idle_timeout[%0d]: still busy after %0d cycles", i, k);
      check($sformatf("idle_wait[%0d]", i), busy_v[i] | done_v[i], 0);
   endtask

   task automatic start_frame(input int i, output int s);
      wait_idle(i);
      s = cyc;
      if (i == 0) start_a = 1'b1; else start_b = 1'b1;
      push_frame(i, s);
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int k = 0;
      while (!done_v[i] && k < BUDGET) begin
         tick();
         k++;
      end
      check($sformatf("done_seen[%0d]", i), done_v[i], 1);
   endtask

   task automatic fill_random(input int i);
      for (int n = 0; n < 4; n++) begin
         if (i == 0) mem_a[n] = 24'($urandom);
         else        mem_b[n] = $urandom;
      end
   endtask

   initial begin
      int s, r, p;
      reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) tick();
      reset_a = 1'b0; reset_b = 1'b0;
      tick();
      check("reset_dout_a", dout_a, 0);    check("reset_busy_a", busy_a, 0);
      check("reset_done_a", done_a, 0);    check("reset_rd_en_a", rd_en_a, 0);
      check("reset_rd_addr_a", rd_addr_a, 0);
      check("reset_dout_b", dout_b, 0);    check("reset_busy_b", busy_b, 0);
      check("reset_done_b", done_b, 0);    check("reset_rd_en_b", rd_en_b, 0);
      check("reset_rd_addr_b", rd_addr_b, 0);

      // Two-pixel reference frame, then alternating-bit pattern.
      mem_a[0] = 24'hFF0000; mem_a[1] = 24'h00FF00;
      start_frame(0, s); wait_done(0);
      mem_a[0] = 24'hAAAAAA; mem_a[1] = 24'hAAAAAA;
      start_frame(0, s); wait_done(0);

      for (int f = 0; f < 3; f++) begin
         fill_random(0);
         start_frame(0, s); wait_done(0);
      end

      // Requests mid-send and during latch must be ignored.
      fill_random(0);
      start_frame(0, s);
      repeat (300) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (NA * BA * T_BIT) tick();
      check("busy_in_latch", busy_a, 1);
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_done(0);

      // Reset in the low phase of bit 10 of pixel 1, then a clean restart.
      fill_random(0);
      start_frame(0, s);
      r = s + 3 + (BA + 10) * T_BIT + 15;
      while (cyc < r) tick();
      reset_a = 1'b1;
      flush(0);
      tick();
      check("reset_mid_dout", dout_a, 0);
      check("reset_mid_busy", busy_a, 0);
      check("reset_mid_done", done_a, 0);
      reset_a = 1'b0;
      repeat (T_LATCH + 50) tick();
      fill_random(0);
      start_frame(0, s); wait_done(0);

      // start_tx held high for three back-to-back frames.
      fill_random(0);
      wait_idle(0);
      p = NA * BA * T_BIT + T_LATCH + 4;
      s = cyc;
      start_a = 1'b1;
      for (int f = 0; f < 3; f++) push_frame(0, s + f * p);
      while (cyc < s + 2 * p + 1) tick();
      start_a = 1'b0;
      wait_done(0);

      // Single 32-bit pixel chain.
      mem_b[0] = 32'h80000001;
      start_frame(1, s); wait_done(1);
      for (int f = 0; f < 2; f++) begin
         fill_random(1);
         start_frame(1, s); wait_done(1);
      end

      repeat (5) tick();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("leftover_events[%0d]", i),
               q_rise[i].size() + q_rd_cyc[i].size() + q_done[i].size(), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
